sramlike_mem_bridge: RTL and testbench



---
 rtl/sramlike_mem_bridge_pkg.sv | 12 +
 rtl/sramlike_mem_bridge.sv | 131 +++++++++++++
 tb/tb_sramlike_mem_bridge.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sramlike_mem_bridge_pkg.sv
// rtl/sramlike_mem_bridge_pkg.sv - shared state encoding and default widths for the memory bridge
package sramlike_mem_bridge_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/sramlike_mem_bridge.sv
// rtl/sramlike_mem_bridge.sv - stall-based CPU port to SRAM-like req/addr_ok/data_ok bridge (optional BRIDGE_PERF_EN counters)
module sramlike_mem_bridge
  import sramlike_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [STRB_W-1:0] cpu_wstrb,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_hold,
  input  logic              cpu_cancel,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef BRIDGE_PERF_EN
  ,
  output logic [31:0]       perf_txn_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  logic [1:0]        state;
  logic              cancel_flag;
  logic              req_wr;
  logic [STRB_W-1:0] req_wstrb;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic cancel_eff;
  logic resp_fire;
  logic txn_done;

  // A response is only meaningful once the request has been accepted, either
  // earlier (WAIT) or in this very cycle (REQ with addr_ok); anything else is stale.
  always_comb begin
    cancel_eff = cancel_flag | cpu_cancel;
    resp_fire  = mem_data_ok &&
                 ((state == ST_WAIT) || ((state == ST_REQ) && mem_addr_ok));
    txn_done   = resp_fire && !cancel_eff;
  end

  // Outputs toward the core and the memory side.
  always_comb begin
    cpu_stall = cpu_req && (state != ST_DONE);
    mem_req   = (state == ST_REQ);
    mem_wr    = req_wr;
    mem_wstrb = req_wstrb;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
  end

  // Transaction FSM with request latch, cancel bookkeeping and read capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cancel_flag <= 1'b0;
      req_wr      <= 1'b0;
      req_wstrb   <= '0;
      req_addr    <= '0;
      req_wdata   <= '0;
      cpu_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req && !cpu_cancel) begin
            req_wr    <= cpu_wr;
            req_wstrb <= cpu_wstrb;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // mem_req must stay up until accepted, so a cancel only marks the result.
          if (resp_fire) begin
            if (!cancel_eff && !req_wr) cpu_rdata <= mem_rdata;
            state       <= cancel_eff ? ST_IDLE : ST_DONE;
            cancel_flag <= 1'b0;
          end else begin
            if (mem_addr_ok) state <= ST_WAIT;
            if (cpu_cancel) cancel_flag <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (resp_fire) begin
            if (!cancel_eff && !req_wr) cpu_rdata <= mem_rdata;
            state       <= cancel_eff ? ST_IDLE : ST_DONE;
            cancel_flag <= 1'b0;
          end else if (cpu_cancel) begin
            cancel_flag <= 1'b1;
          end
        end
        default: begin
          // DONE: the result stays visible for as long as the pipeline is frozen.
          if (!cpu_hold || cpu_cancel) state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BRIDGE_PERF_EN
  // Free-running wrap-around counters of completed transactions and stall cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_txn_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (txn_done) perf_txn_cnt <= perf_txn_cnt + 32'd1;
      if (cpu_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Completion tracking only feeds the counters; keep it referenced.
  logic txn_done_unused;
  always_comb txn_done_unused = txn_done;
`endif

endmodule

// File: tb/tb_sramlike_mem_bridge.sv
// tb/tb_sramlike_mem_bridge.sv - directed self-checking bench for sramlike_mem_bridge
module tb_sramlike_mem_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req;
  logic        cpu_wr;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_hold;
  logic        cpu_cancel;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
`ifdef BRIDGE_PERF_EN
  logic [31:0] perf_txn_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sramlike_mem_bridge dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_hold   (cpu_hold),
    .cpu_cancel (cpu_cancel),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata  (mem_rdata)
`ifdef BRIDGE_PERF_EN
    ,
    .perf_txn_cnt  (perf_txn_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and,
  // after a settle delay, outputs are sampled well away from the edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    resetn = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_wstrb = 4'h0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_hold = 1'b0; cpu_cancel = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    settle();
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_rdata", {32'd0, cpu_rdata}, 64'd0);
    cpu_req = 1'b1; settle();
    chk("rst_stall_eq_req", {63'd0, cpu_stall}, 64'd1);
    cpu_req = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // Test 1: minimum-latency read
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'hBFC00010; settle();
    chk("t1_c0_stall", {63'd0, cpu_stall}, 64'd1);
    chk("t1_c0_mem_req", {63'd0, mem_req}, 64'd0);
    tick();
    mem_addr_ok = 1'b1; settle();
    chk("t1_c1_mem_req", {63'd0, mem_req}, 64'd1);
    chk("t1_c1_mem_addr", {32'd0, mem_addr}, {32'd0, 32'hBFC00010});
    chk("t1_c1_mem_wr", {63'd0, mem_wr}, 64'd0);
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
    chk("t1_c2_mem_req", {63'd0, mem_req}, 64'd0);
    chk("t1_c2_stall", {63'd0, cpu_stall}, 64'd1);
    tick();
    mem_data_ok = 1'b0; mem_rdata = 32'h0; settle();
    chk("t1_c3_stall", {63'd0, cpu_stall}, 64'd0);
    chk("t1_c3_rdata", {32'd0, cpu_rdata}, {32'd0, 32'hDEADBEEF});
    tick();
    cpu_req = 1'b0; settle();
    chk("t1_c4_idle", {62'd0, dut.state}, 64'd0);
    chk("t1_c4_mem_req", {63'd0, mem_req}, 64'd0);

    // Test 2: write with addr_ok delayed 3 cycles, stale data_ok in REQ ignored
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_wstrb = 4'b0011;
    cpu_addr = 32'hA0000004; cpu_wdata = 32'hCAFEF00D;
    tick();
    cpu_addr = 32'h0BAD0BAD; cpu_wdata = 32'h0; cpu_wstrb = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      mem_addr_ok = (i == 3);
      mem_data_ok = (i == 1);
      mem_rdata   = 32'h77777777;
      settle();
      chk($sformatf("t2_req_%0d", i), {63'd0, mem_req}, 64'd1);
      chk($sformatf("t2_addr_%0d", i), {32'd0, mem_addr}, {32'd0, 32'hA0000004});
      chk($sformatf("t2_wdata_%0d", i), {32'd0, mem_wdata}, {32'd0, 32'hCAFEF00D});
      chk($sformatf("t2_wstrb_%0d", i), {60'd0, mem_wstrb}, 64'd3);
      chk($sformatf("t2_wr_%0d", i), {63'd0, mem_wr}, 64'd1);
      tick();
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h11111111; settle();
    chk("t2_wait_mem_req", {63'd0, mem_req}, 64'd0);
    chk("t2_wait_stall", {63'd0, cpu_stall}, 64'd1);
    tick();
    mem_data_ok = 1'b0; settle();
    chk("t2_done_stall", {63'd0, cpu_stall}, 64'd0);
    chk("t2_rdata_kept", {32'd0, cpu_rdata}, {32'd0, 32'hDEADBEEF});
    tick();
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_wstrb = 4'h0; settle();
    chk("t2_idle", {62'd0, dut.state}, 64'd0);

    // Test 3: same-cycle addr_ok + data_ok, then test 4: hold in DONE
    cpu_req = 1'b1; cpu_addr = 32'h00001000;
    tick();
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; cpu_hold = 1'b1; settle();
    chk("t3_rdata", {32'd0, cpu_rdata}, {32'd0, 32'h12345678});
    chk("t3_stall", {63'd0, cpu_stall}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      mem_rdata = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h00000000;
      mem_data_ok = (i == 2);
      tick();
      settle();
      chk($sformatf("t4_rdata_%0d", i), {32'd0, cpu_rdata}, {32'd0, 32'h12345678});
      chk($sformatf("t4_stall_%0d", i), {63'd0, cpu_stall}, 64'd0);
      chk($sformatf("t4_mem_req_%0d", i), {63'd0, mem_req}, 64'd0);
    end
    mem_data_ok = 1'b0; cpu_hold = 1'b0; cpu_req = 1'b0;
    tick();
    settle();
    chk("t4_idle", {62'd0, dut.state}, 64'd0);

    // Test 5: cancel in WAIT drops result; next request proceeds normally
    cpu_req = 1'b1; cpu_addr = 32'h00002000;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0; cpu_cancel = 1'b1; settle();
    chk("t5_wait_stall", {63'd0, cpu_stall}, 64'd1);
    tick();
    cpu_cancel = 1'b0; cpu_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hAAAA5555; settle();
    chk("t5_mem_req", {63'd0, mem_req}, 64'd0);
    tick();
    mem_data_ok = 1'b0; settle();
    chk("t5_idle", {62'd0, dut.state}, 64'd0);
    chk("t5_rdata_kept", {32'd0, cpu_rdata}, {32'd0, 32'h12345678});
    chk("t5_flag_clear", {63'd0, dut.cancel_flag}, 64'd0);
    cpu_req = 1'b1; cpu_addr = 32'h00003000;
    tick();
    mem_addr_ok = 1'b1; settle();
    chk("t5b_mem_addr", {32'd0, mem_addr}, {32'd0, 32'h00003000});
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h5A5A0001;
    tick();
    mem_data_ok = 1'b0; settle();
    chk("t5b_stall", {63'd0, cpu_stall}, 64'd0);
    chk("t5b_rdata", {32'd0, cpu_rdata}, {32'd0, 32'h5A5A0001});
`ifdef BRIDGE_PERF_EN
    chk("perf_txn_before_rst", {32'd0, perf_txn_cnt}, 64'd4);
`endif
    tick();
    cpu_req = 1'b0;
    tick();

    // Test 6: reset mid-WAIT, stray data_ok afterwards
    cpu_req = 1'b1; cpu_addr = 32'h00004000;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0; resetn = 1'b0;
    tick();
    resetn = 1'b1; cpu_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hFFFF0000; settle();
    chk("t6_idle", {62'd0, dut.state}, 64'd0);
    chk("t6_mem_req", {63'd0, mem_req}, 64'd0);
    chk("t6_rdata_rst", {32'd0, cpu_rdata}, 64'd0);
`ifdef BRIDGE_PERF_EN
    chk("t6_perf_txn", {32'd0, perf_txn_cnt}, 64'd0);
    chk("t6_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
`endif
    tick();
    mem_data_ok = 1'b0; settle();
    chk("t6_stray_idle", {62'd0, dut.state}, 64'd0);
    chk("t6_stray_rdata", {32'd0, cpu_rdata}, 64'd0);
    chk("t6_stray_stall", {63'd0, cpu_stall}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
